midori_sbox_layer_ctrl: RTL and testbench

MIDORI_SBOX_LAYER_CTRL -- requirements
Module: midori_sbox_layer_ctrl

---
 rtl/midori_ctrl_pkg.sv | 25 ++
 rtl/midori_tag_pipe.sv | 33 +++
 rtl/midori_sbox_layer_ctrl.sv | 141 ++++++++++++++
 tb/tb_midori_sbox_layer_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/midori_ctrl_pkg.sv
// Shared types and constants for the Midori masked S-box layer controller.
package midori_ctrl_pkg;

  localparam int NIBBLES = 16;
  localparam int SHARES  = 3;
  localparam int RAND_W  = 24;
  localparam int STATE_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [STATE_W-1:0] put_nibble(input logic [STATE_W-1:0] s,
                                                    input logic [3:0]         idx,
                                                    input logic [3:0]         v);
    logic [STATE_W-1:0] r;
    r = s;
    r[{idx, 2'b00} +: 4] = v;
    return r;
  endfunction

endpackage

// File: rtl/midori_tag_pipe.sv
// Tag delay line {valid, nibble index} matching the external S-box latency.
module midori_tag_pipe #(
  parameter int LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       in_vld,
  input  logic [3:0] in_idx,
  output logic       out_vld,
  output logic [3:0] out_idx
);

  logic [LATENCY-1:0] vld_p;
  logic [3:0]         idx_p [LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      vld_p <= '0;
      for (int i = 0; i < LATENCY; i++) idx_p[i] <= '0;
    end else begin
      vld_p[0] <= in_vld;
      idx_p[0] <= in_idx;
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        idx_p[i] <= idx_p[i-1];
      end
    end
  end

  assign out_vld = vld_p[LATENCY-1];
  assign out_idx = idx_p[LATENCY-1];

endmodule

// File: rtl/midori_sbox_layer_ctrl.sv
// Feeds 16 share nibbles through an external pipelined masked S-box and reassembles the result.
// Optional MIDORI_IDLE_CLEAR_EN: zero sbox_x*/sbox_r in every cycle without an issue.
module midori_sbox_layer_ctrl
  import midori_ctrl_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_s1,
  input  logic [STATE_W-1:0] in_s2,
  input  logic [STATE_W-1:0] in_s3,
  input  logic               rand_valid,
  input  logic [RAND_W-1:0]  rand_i,
  output logic [3:0]         sbox_x1,
  output logic [3:0]         sbox_x2,
  output logic [3:0]         sbox_x3,
  output logic [RAND_W-1:0]  sbox_r,
  input  logic [3:0]         sbox_y1,
  input  logic [3:0]         sbox_y2,
  input  logic [3:0]         sbox_y3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_s1,
  output logic [STATE_W-1:0] out_s2,
  output logic [STATE_W-1:0] out_s3,
  output logic               busy
);

  state_e             state;
  logic [3:0]         issue_cnt;
  logic [4:0]         collect_cnt;
  logic [STATE_W-1:0] share1_q, share2_q, share3_q;
  logic               tag_vld_p0;
  logic [3:0]         tag_idx_p0;
  logic               tag_vld_pl;
  logic [3:0]         tag_idx_pl;
  logic               fire;

  assign fire = (state == ISSUE) && rand_valid;

  // Input shares are plain data: captured on acceptance only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      share1_q <= in_s1;
      share2_q <= in_s2;
      share3_q <= in_s3;
    end
  end

  // Stage p0: issue to the S-box, tag launched alongside the registered nibbles.
  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      collect_cnt <= '0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_s1      <= '0;
      out_s2      <= '0;
      out_s3      <= '0;
      sbox_x1     <= '0;
      sbox_x2     <= '0;
      sbox_x3     <= '0;
      sbox_r      <= '0;
      tag_vld_p0  <= 1'b0;
      tag_idx_p0  <= '0;
    end else begin
      tag_vld_p0 <= fire;
      tag_idx_p0 <= issue_cnt;
      if (fire) begin
        sbox_x1 <= share1_q[{issue_cnt, 2'b00} +: 4];
        sbox_x2 <= share2_q[{issue_cnt, 2'b00} +: 4];
        sbox_x3 <= share3_q[{issue_cnt, 2'b00} +: 4];
        sbox_r  <= rand_i;
      end
`ifdef MIDORI_IDLE_CLEAR_EN
      else begin
        sbox_x1 <= '0;
        sbox_x2 <= '0;
        sbox_x3 <= '0;
        sbox_r  <= '0;
      end
`endif
      // Stage p(L): tag emerges aligned with the S-box result shares.
      if (tag_vld_pl) begin
        out_s1      <= put_nibble(out_s1, tag_idx_pl, sbox_y1);
        out_s2      <= put_nibble(out_s2, tag_idx_pl, sbox_y2);
        out_s3      <= put_nibble(out_s3, tag_idx_pl, sbox_y3);
        collect_cnt <= collect_cnt + 5'd1;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            issue_cnt   <= '0;
            collect_cnt <= '0;
            state       <= ISSUE;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ISSUE: begin
          if (rand_valid) begin
            issue_cnt <= issue_cnt + 4'd1;
            if (issue_cnt == 4'(NIBBLES - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (tag_vld_pl && collect_cnt == 5'(NIBBLES - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  midori_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_i   (rst_i),
    .in_vld  (tag_vld_p0),
    .in_idx  (tag_idx_p0),
    .out_vld (tag_vld_pl),
    .out_idx (tag_idx_pl)
  );

endmodule

// File: tb/tb_midori_sbox_layer_ctrl.sv
// Bench for midori_sbox_layer_ctrl with a behavioural 4-cycle masked Midori Sb0 model.
module tb_midori_sbox_layer_ctrl;

  localparam logic [63:0] SB0_TBL = 64'hcad3ebf789150246;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_s1 = '0, in_s2 = '0, in_s3 = '0;
  logic        rand_valid = 1'b0;
  logic [23:0] rand_i = '0;
  logic [3:0]  sbox_x1, sbox_x2, sbox_x3;
  logic [23:0] sbox_r;
  logic [3:0]  sbox_y1, sbox_y2, sbox_y3;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_s1, out_s2, out_s3;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [3:0]  last_x1, last_x2, last_x3;
  logic [23:0] last_r;

  always #5 clk = ~clk;

  midori_sbox_layer_ctrl #(.LATENCY(4)) dut (
    .clk(clk), .rst_i(rst_i), .in_valid(in_valid), .in_ready(in_ready),
    .in_s1(in_s1), .in_s2(in_s2), .in_s3(in_s3),
    .rand_valid(rand_valid), .rand_i(rand_i),
    .sbox_x1(sbox_x1), .sbox_x2(sbox_x2), .sbox_x3(sbox_x3), .sbox_r(sbox_r),
    .sbox_y1(sbox_y1), .sbox_y2(sbox_y2), .sbox_y3(sbox_y3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3), .busy(busy)
  );

  function automatic logic [3:0] sb0(input logic [3:0] v);
    return SB0_TBL[(15 - int'(v)) * 4 +: 4];
  endfunction

  function automatic logic [63:0] sb0_word(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = sb0(x[i*4 +: 4]);
    return r;
  endfunction

  // S-box model: unmask, substitute, re-share with two nibbles of the refresh word.
  logic [3:0] m1_p [4];
  logic [3:0] m2_p [4];
  logic [3:0] m3_p [4];
  always @(posedge clk) begin
    m1_p[0] <= sbox_r[3:0];
    m2_p[0] <= sbox_r[7:4];
    m3_p[0] <= sb0(sbox_x1 ^ sbox_x2 ^ sbox_x3) ^ sbox_r[3:0] ^ sbox_r[7:4];
    for (int i = 1; i < 4; i++) begin
      m1_p[i] <= m1_p[i-1];
      m2_p[i] <= m2_p[i-1];
      m3_p[i] <= m3_p[i-1];
    end
  end
  assign sbox_y1 = m1_p[3];
  assign sbox_y2 = m2_p[3];
  assign sbox_y3 = m3_p[3];

  task automatic do_txn(input logic [63:0] bub, input int exp_lat, input int hold, input bit pulse);
    logic [63:0] a, b, c, e1, e2, exp_x;
    logic [63:0] h1, h2, h3;
    logic [23:0] rw [16];
    int issued, n;
    bit got;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    c = {$urandom, $urandom};
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL in_ready_idle: got %b want 1", in_ready);
    end
    in_s1 = a; in_s2 = b; in_s3 = c; in_valid = 1'b1; rand_valid = 1'b0;
    sb_q.push_back(sb0_word(a ^ b ^ c));
    @(posedge clk); #1;
    in_valid = 1'b0;
    issued = 0; n = 0; got = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      if (pulse && n == 5) begin
        in_valid = 1'b1; in_s1 = ~a; in_s2 = ~b; in_s3 = ~c;
      end else in_valid = 1'b0;
      rand_valid = !bub[n+1];
      rand_i = 24'($urandom);
      if (rand_valid && issued < 16) begin
        rw[issued] = rand_i;
        issued++;
      end
      @(posedge clk); n++; #1;
      if (out_valid === 1'b1) got = 1;
    end
    in_valid = 1'b0; rand_valid = 1'b0;
    n_cmp++;
    if (!got || n != exp_lat) begin
      n_err++; $display("FAIL latency: out_valid at cycle %0d (seen=%0b) want %0d", n, got, exp_lat);
    end
    if (got) begin
      exp_x = sb_q.pop_front();
      for (int k = 0; k < 16; k++) begin
        e1[k*4 +: 4] = rw[k][3:0];
        e2[k*4 +: 4] = rw[k][7:4];
      end
      n_cmp++;
      if ((out_s1 ^ out_s2 ^ out_s3) !== exp_x) begin
        n_err++; $display("FAIL result_xor: got %h want %h", out_s1 ^ out_s2 ^ out_s3, exp_x);
      end
      n_cmp++;
      if (out_s1 !== e1 || out_s2 !== e2) begin
        n_err++; $display("FAIL share_routing: s1=%h s2=%h want %h %h", out_s1, out_s2, e1, e2);
      end
      h1 = out_s1; h2 = out_s2; h3 = out_s3;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (pulse && i == 1) begin
          in_valid = 1'b1; in_s1 = ~a; in_s2 = ~b; in_s3 = ~c;
        end else in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, in_ready, out_s1, out_s2, out_s3} !== {1'b1, 1'b0, h1, h2, h3}) begin
          n_err++;
          $display("FAIL done_hold: vld=%b rdy=%b s=%h/%h/%h want 1 0 %h/%h/%h",
                   out_valid, in_ready, out_s1, out_s2, out_s3, h1, h2, h3);
        end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++;
      if ({in_ready, busy, out_valid} !== 3'b100) begin
        n_err++; $display("FAIL release_idle: rdy/busy/vld=%b want 100", {in_ready, busy, out_valid});
      end
      last_x1 = a[63:60]; last_x2 = b[63:60]; last_x3 = c[63:60]; last_r = rw[15];
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      n_err++; $display("FAIL reset_ctrl: rdy/busy/vld=%b want 100", {in_ready, busy, out_valid});
    end
    n_cmp++;
    if ({out_s1, out_s2, out_s3} !== '0) begin
      n_err++; $display("FAIL reset_out: %h %h %h want 0", out_s1, out_s2, out_s3);
    end
    n_cmp++;
    if ({sbox_x1, sbox_x2, sbox_x3, sbox_r} !== '0) begin
      n_err++; $display("FAIL reset_sbox: %h %h %h %h want 0", sbox_x1, sbox_x2, sbox_x3, sbox_r);
    end
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_basic();
    do_txn(64'd0, 21, 0, 1'b0);
  endtask

  task automatic test_bubbles();
    logic [63:0] m;
    m = '0; m[3] = 1'b1; m[4] = 1'b1; m[10] = 1'b1;
    do_txn(m, 24, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_txn(64'd0, 21, 5, 1'b0);
  endtask

  task automatic test_in_valid_ignored();
    do_txn(64'd0, 21, 3, 1'b1);
  endtask

  task automatic test_idle_outputs();
    do_txn(64'd0, 21, 0, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
`ifdef MIDORI_IDLE_CLEAR_EN
    if ({sbox_x1, sbox_x2, sbox_x3, sbox_r} !== '0) begin
      n_err++; $display("FAIL idle_clear: %h %h %h %h want 0", sbox_x1, sbox_x2, sbox_x3, sbox_r);
    end
`else
    if ({sbox_x1, sbox_x2, sbox_x3, sbox_r} !== {last_x1, last_x2, last_x3, last_r}) begin
      n_err++; $display("FAIL idle_hold: %h %h %h %h want %h %h %h %h",
                        sbox_x1, sbox_x2, sbox_x3, sbox_r, last_x1, last_x2, last_x3, last_r);
    end
`endif
  endtask

  task automatic test_reset_mid_issue();
    int stale;
    @(negedge clk);
    in_s1 = {$urandom, $urandom}; in_s2 = {$urandom, $urandom}; in_s3 = {$urandom, $urandom};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      rand_valid = 1'b1; rand_i = 24'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      n_err++; $display("FAIL midreset_ctrl: rdy/busy/vld=%b want 100", {in_ready, busy, out_valid});
    end
    n_cmp++;
    if ({out_s1, out_s2, out_s3} !== '0) begin
      n_err++; $display("FAIL midreset_out: %h %h %h want 0", out_s1, out_s2, out_s3);
    end
    @(negedge clk);
    rst_i = 1'b1; rand_valid = 1'b0;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if ({out_s1, out_s2, out_s3} !== '0 || busy !== 1'b0) stale++;
    end
    n_cmp++;
    if (stale != 0) begin
      n_err++; $display("FAIL stale_tag: %0d cycles with writes/busy after reset want 0", stale);
    end
    do_txn(64'd0, 21, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_backpressure();
    test_in_valid_ignored();
    test_reset_mid_issue();
    test_idle_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
